// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding,
// default register-index width and the hard-wired zero register.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int ZERO_REG       = 0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DMISS = 2'd1,
        ST_IMISS = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: an ID-stage source matches the
// destination of a load sitting in EX. Writes to the zero register never count.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    output logic                  lu
);

    logic rd_nonzero;
    logic rs1_hit;
    logic rs2_hit;

    assign rd_nonzero = (ex_rd != REG_ADDR_W'(ZERO_REG));
    assign rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);
    assign lu         = ex_is_load && rd_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (RUN / DMISS / IMISS).
// Define PIPE_HAZARD_PERF_EN to add saturating stall/D-miss/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
`ifdef PIPE_HAZARD_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  ex_branch_taken,
    input  logic                  icache_req,
    input  logic                  icache_ready,
    input  logic                  dcache_req,
    input  logic                  dcache_ready,
    output logic                  stall_pc,
    output logic                  pc_redirect,
    output logic                  stall_if_id,
    output logic                  stall_id_ex,
    output logic                  stall_ex_mem,
    output logic                  stall_mem_wb,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [1:0]            ctrl_state
`ifdef PIPE_HAZARD_PERF_EN
    ,
    input  logic                  perf_clr,
    output logic [CNT_W-1:0]      perf_stall_cyc,
    output logic [CNT_W-1:0]      perf_dmiss_cyc,
    output logic [CNT_W-1:0]      perf_flush_cnt
`endif
);

    ctrl_state_e state_q, state_d;
    logic        kill_pending_q, kill_pending_d;
    logic        lu;
    logic        dmiss;
    logic        imiss;
    logic        freeze;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .lu         (lu)
    );

    assign dmiss  = dcache_req && !dcache_ready;
    assign imiss  = icache_req && !icache_ready;
    // Once frozen, only dcache_ready releases us, whatever dcache_req does.
    assign freeze = (state_q == ST_DMISS) ? !dcache_ready : dmiss;

    always_comb begin
        state_d        = state_q;
        kill_pending_d = kill_pending_q;
        stall_pc       = 1'b0;
        pc_redirect    = 1'b0;
        stall_if_id    = 1'b0;
        stall_id_ex    = 1'b0;
        stall_ex_mem   = 1'b0;
        stall_mem_wb   = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;

        if (freeze) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            stall_mem_wb = 1'b1;
            state_d      = ST_DMISS;
        end else if (state_q == ST_IMISS) begin
            stall_pc    = 1'b1;
            flush_if_id = 1'b1;
            if (ex_branch_taken) begin
                pc_redirect    = 1'b1;
                flush_id_ex    = 1'b1;
                stall_pc       = 1'b0;
                kill_pending_d = 1'b1;
            end
            if (icache_ready) begin
                state_d        = ST_RUN;
                kill_pending_d = 1'b0;
                // A fetch that returns after a redirect is wrong-path and is dropped.
                if (!kill_pending_q && !ex_branch_taken) begin
                    flush_if_id = 1'b0;
                    stall_pc    = 1'b0;
                end
            end
        end else begin
            state_d = ST_RUN;
            if (ex_branch_taken) begin
                pc_redirect = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (lu) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (imiss) begin
                stall_pc    = 1'b1;
                flush_if_id = 1'b1;
                if (state_q == ST_RUN) begin
                    state_d = ST_IMISS;
                end
            end
        end

        if (!reset) begin
            stall_pc     = 1'b0;
            pc_redirect  = 1'b0;
            stall_if_id  = 1'b0;
            stall_id_ex  = 1'b0;
            stall_ex_mem = 1'b0;
            stall_mem_wb = 1'b0;
            flush_if_id  = 1'b0;
            flush_id_ex  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            kill_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            kill_pending_q <= kill_pending_d;
        end
    end

    assign ctrl_state = state_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [2:0]       perf_inc;
    logic [CNT_W-1:0] perf_cnt_q [3];

    assign perf_inc[0] = stall_pc;
    assign perf_inc[1] = (state_q == ST_DMISS);
    assign perf_inc[2] = flush_id_ex;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_perf
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    perf_cnt_q[gi] <= '0;
                end else if (perf_clr) begin
                    perf_cnt_q[gi] <= '0;
                end else if (perf_inc[gi] && (perf_cnt_q[gi] != {CNT_W{1'b1}})) begin
                    perf_cnt_q[gi] <= perf_cnt_q[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign perf_stall_cyc = perf_cnt_q[0];
    assign perf_dmiss_cyc = perf_cnt_q[1];
    assign perf_flush_cnt = perf_cnt_q[2];
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed output vectors per cycle.
module tb_pipe_hazard_ctrl;

    localparam int W = 5;

    // Output vector layout: {stall_pc, pc_redirect, stall_if_id, stall_id_ex,
    // stall_ex_mem, stall_mem_wb, flush_if_id, flush_id_ex, ctrl_state[1:0]}
    localparam logic [9:0] P_SPC  = 10'b10_0000_0000;
    localparam logic [9:0] P_RED  = 10'b01_0000_0000;
    localparam logic [9:0] P_SIF  = 10'b00_1000_0000;
    localparam logic [9:0] P_SALL = 10'b00_1111_0000;
    localparam logic [9:0] P_FIF  = 10'b00_0000_1000;
    localparam logic [9:0] P_FEX  = 10'b00_0000_0100;
    localparam logic [9:0] M_ALL  = 10'b11_1111_1111;
    localparam logic [9:0] S_RUN  = 10'd0;
    localparam logic [9:0] S_DM   = 10'd1;
    localparam logic [9:0] S_IM   = 10'd2;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] id_rs1, id_rs2, ex_rd;
    logic         id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken;
    logic         icache_req, icache_ready, dcache_req, dcache_ready;
    logic         stall_pc, pc_redirect, stall_if_id, stall_id_ex;
    logic         stall_ex_mem, stall_mem_wb, flush_if_id, flush_id_ex;
    logic [1:0]   ctrl_state;
`ifdef PIPE_HAZARD_PERF_EN
    logic         perf_clr;
    logic [31:0]  perf_stall_cyc, perf_dmiss_cyc, perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_is_load      (ex_is_load),
        .ex_branch_taken (ex_branch_taken),
        .icache_req      (icache_req),
        .icache_ready    (icache_ready),
        .dcache_req      (dcache_req),
        .dcache_ready    (dcache_ready),
        .stall_pc        (stall_pc),
        .pc_redirect     (pc_redirect),
        .stall_if_id     (stall_if_id),
        .stall_id_ex     (stall_id_ex),
        .stall_ex_mem    (stall_ex_mem),
        .stall_mem_wb    (stall_mem_wb),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .ctrl_state      (ctrl_state)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .perf_clr        (perf_clr),
        .perf_stall_cyc  (perf_stall_cyc),
        .perf_dmiss_cyc  (perf_dmiss_cyc),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    task automatic clr_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_is_load = 1'b0;
        ex_branch_taken = 1'b0;
        icache_req = 1'b0; icache_ready = 1'b0;
        dcache_req = 1'b0; dcache_ready = 1'b0;
`ifdef PIPE_HAZARD_PERF_EN
        perf_clr = 1'b0;
`endif
    endtask

    task automatic chk(input string tag, input logic [9:0] exp, input logic [9:0] mask);
        logic [9:0] obs;
        obs = {stall_pc, pc_redirect, stall_if_id, stall_id_ex, stall_ex_mem,
               stall_mem_wb, flush_if_id, flush_id_ex, ctrl_state};
        checks++;
        assert ((obs & mask) === (exp & mask)) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (mask %b)", tag, obs, exp, mask);
        end
        $display("check %-14s obs=%b exp=%b", tag, obs, exp);
    endtask

    // Inputs already applied; sample mid-cycle, then move just past the next edge.
    task automatic cyc(input string tag, input logic [9:0] exp, input logic [9:0] mask);
        @(negedge clk);
        chk(tag, exp, mask);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_inputs();
        reset = 1'b0;
        dcache_req = 1'b1;
        ex_branch_taken = 1'b1;
        cyc("reset", S_RUN, M_ALL);
        clr_inputs();
        reset = 1'b1;
        cyc("idle", S_RUN, M_ALL);

        // Load-use on rs1, then the load moves on
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        cyc("lu_rs1", P_SPC | P_SIF | P_FEX | S_RUN, M_ALL);
        clr_inputs();
        cyc("lu_after", S_RUN, M_ALL);
        ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; id_rs1 = 5'd3;
        cyc("lu_rs2", P_SPC | P_SIF | P_FEX | S_RUN, M_ALL);
        id_use_rs2 = 1'b0;
        cyc("lu_rs2_unused", S_RUN, M_ALL);
        clr_inputs();
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        cyc("lu_x0", S_RUN, M_ALL);
        clr_inputs();

        // D-miss held for four cycles
        dcache_req = 1'b1;
        cyc("dmiss_1", P_SPC | P_SALL | S_RUN, M_ALL);
        cyc("dmiss_2", P_SPC | P_SALL | S_DM, M_ALL);
        cyc("dmiss_3", P_SPC | P_SALL | S_DM, M_ALL);
        cyc("dmiss_4", P_SPC | P_SALL | S_DM, M_ALL);
        dcache_ready = 1'b1;
        cyc("dmiss_ready", S_DM, M_ALL);
        clr_inputs();
        cyc("dmiss_done", S_RUN, M_ALL);

        // D-cache hit on the request cycle
        dcache_req = 1'b1; dcache_ready = 1'b1;
        cyc("dhit", S_RUN, M_ALL);
        clr_inputs();
        cyc("dhit_after", S_RUN, M_ALL);

        // Branch beats load-use
        ex_branch_taken = 1'b1;
        ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
        cyc("br_over_lu", P_RED | P_FIF | P_FEX | S_RUN, M_ALL);
        clr_inputs();

        // I-miss with a branch during the miss: returned fetch is dropped
        icache_req = 1'b1;
        cyc("imiss_1", P_SPC | P_FIF | S_RUN, M_ALL);
        ex_branch_taken = 1'b1;
        cyc("imiss_br", P_RED | P_FIF | P_FEX | S_IM, M_ALL);
        ex_branch_taken = 1'b0;
        cyc("imiss_3", P_SPC | P_FIF | S_IM, M_ALL);
        icache_ready = 1'b1;
        cyc("imiss_kill", P_FIF | S_IM, P_FIF | P_RED | P_FEX | 10'b11);
        clr_inputs();
        cyc("imiss_done", S_RUN, M_ALL);

        // Plain I-miss afterwards: kill flag must be gone
        icache_req = 1'b1;
        cyc("imiss2_1", P_SPC | P_FIF | S_RUN, M_ALL);
        cyc("imiss2_2", P_SPC | P_FIF | S_IM, M_ALL);
        icache_ready = 1'b1;
        cyc("imiss2_ready", S_IM, M_ALL);
        clr_inputs();
        cyc("imiss2_done", S_RUN, M_ALL);

        // D-miss arriving during an I-miss
        icache_req = 1'b1;
        cyc("id_1", P_SPC | P_FIF | S_RUN, M_ALL);
        dcache_req = 1'b1;
        cyc("id_freeze", P_SPC | P_SALL | S_IM, M_ALL);
        cyc("id_frozen", P_SPC | P_SALL | S_DM, M_ALL);
        dcache_ready = 1'b1;
        cyc("id_dready", P_SPC | P_FIF | S_DM, M_ALL);
        dcache_req = 1'b0; dcache_ready = 1'b0;
        cyc("id_redetect", P_SPC | P_FIF | S_RUN, M_ALL);
        icache_ready = 1'b1;
        cyc("id_iready", S_IM, M_ALL);
        clr_inputs();

        // D-miss with a branch held in EX
        dcache_req = 1'b1; ex_branch_taken = 1'b1;
        cyc("dbr_1", P_SPC | P_SALL | S_RUN, M_ALL);
        cyc("dbr_2", P_SPC | P_SALL | S_DM, M_ALL);
        dcache_ready = 1'b1;
        cyc("dbr_ready", P_RED | P_FIF | P_FEX | S_DM, M_ALL);
        clr_inputs();
        cyc("dbr_done", S_RUN, M_ALL);

        // Asynchronous reset in the middle of a D-miss
        dcache_req = 1'b1;
        cyc("drst_1", P_SPC | P_SALL | S_RUN, M_ALL);
        cyc("drst_2", P_SPC | P_SALL | S_DM, M_ALL);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_async", S_RUN, M_ALL);
`ifdef PIPE_HAZARD_PERF_EN
        checks++;
        assert ((perf_stall_cyc | perf_dmiss_cyc | perf_flush_cnt) === 32'd0) else begin
            errors++;
            $error("FAIL perf_rst: observed %0d/%0d/%0d expected 0/0/0",
                   perf_stall_cyc, perf_dmiss_cyc, perf_flush_cnt);
        end
`endif
        cyc("rst_hold", S_RUN, M_ALL);
        clr_inputs();
        reset = 1'b1;
        cyc("rst_release", S_RUN, M_ALL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
